// File: rtl/wb_stream_pkg.sv
// Shared state encoding and protocol bytes for the byte-stream Wishbone master.
package wb_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP,
    RDATA
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] STAT_ACK  = 8'h06;
  localparam logic [7:0] STAT_NAK  = 8'h15;

endpackage

// File: rtl/wb_stream_timeout.sv
// Bus-cycle watchdog: counts un-acked cycles and flags expiry at TIMEOUT-1.
module wb_stream_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q;

  assign expired_o = (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/wb_stream_master.sv
// Command-byte stream to classic Wishbone single-cycle master with status/read-data byte stream back.
module wb_stream_master
  import wb_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  input  logic                    ack_i,
  output logic                    cyc_o,
  output logic                    busy
);

  localparam int unsigned NA = ADDR_WIDTH / 8;
  localparam int unsigned ND = DATA_WIDTH / 8;

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic                    we_q;
  logic                    cyc_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    expired;

  wb_stream_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != BUS),
    .en_i     ((state_q == BUS) && !ack_i),
    .expired_o(expired)
  );

  assign rx_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign busy     = (state_q != IDLE);
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign we_o     = cyc_q & we_q;
  assign sel_o    = cyc_q ? '1 : '0;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            we_q    <= (rx_data == CMD_WRITE);
            cnt_q   <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            // little-endian: each new byte enters at the top and shifts down
            adr_q <= ADDR_WIDTH'({rx_data, adr_q} >> 8);
            if (cnt_q == 8'(NA - 1)) begin
              cnt_q <= '0;
              if (we_q) begin
                state_q <= DATA;
              end else begin
                cyc_q   <= 1'b1;
                state_q <= BUS;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            dat_q <= DATA_WIDTH'({rx_data, dat_q} >> 8);
            if (cnt_q == 8'(ND - 1)) begin
              cnt_q   <= '0;
              cyc_q   <= 1'b1;
              state_q <= BUS;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        BUS: begin
          // ack wins over a same-cycle expiry
          if (ack_i) begin
            cyc_q      <= 1'b0;
            if (!we_q) rd_q <= dat_i;
            tx_data_q  <= STAT_ACK;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
          end else if (expired) begin
            cyc_q      <= 1'b0;
            tx_data_q  <= STAT_NAK;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (tx_ready) begin
            if (!we_q && tx_data_q == STAT_ACK) begin
              tx_data_q <= rd_q[7:0];
              rd_q      <= DATA_WIDTH'(rd_q >> 8);
              cnt_q     <= '0;
              state_q   <= RDATA;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        RDATA: begin
          if (tx_ready) begin
            if (cnt_q == 8'(ND - 1)) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              tx_data_q <= rd_q[7:0];
              rd_q      <= DATA_WIDTH'(rd_q >> 8);
              cnt_q     <= cnt_q + 8'd1;
            end
          end
        end
        default: begin
          cyc_q      <= 1'b0;
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule
